fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Pipeline control block for the 5-stage core (F/D/E/M/W).
- Tracks register-destination metadata for instructions as they move from D through W, and produces the 2-bit forwarding selects for both E-stage ALU operand muxes.
- Generates a pipeline-wide stall while a data-memory access in M waits for the memory to be ready, and squashes E on a taken branch.
- Selects are the control end of the E-stage operand forwarding muxes.

Parameters:
- REG_AW, 5, register address width.
- STALL_CW, 16, width of the stall-cycle counter (optional feature only).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- i_addr_rsD  in  REG_AW  D-stage source A register
- i_addr_rtD  in  REG_AW  D-stage source B register
- i_addr_dstD  in  REG_AW  D-stage destination register
- i_con_regwriteD  in  1  D instruction writes the register file
- i_con_loadD  in  1  D instruction is a load
- i_con_storeD  in  1  D instruction is a store
- i_con_brtakenE  in  1  taken branch/jump resolved in E
- i_con_memready  in  1  data memory accepts or returns this cycle
- o_con_fba  out  2  operand A forwarding select for E
- o_con_fbb  out  2  operand B forwarding select for E
- o_con_stall  out  1  freeze F, D, E, M and W pipeline registers
- o_con_flushE  out  1  load a bubble into E
- o_con_wbenable  out  1  register-file write enable for W

Behaviour:
- Select encoding:
  - 00: register-file operand.
  - 01: W write-back result.
  - 10: M ALU result.
  - 11: M memory output (load in M).
- Internal shadow stages:
  - E: rs, rt.
  - M: dst, regwrite, load, store.
  - W: dst, regwrite.
- Reset: all shadow valid/regwrite/load/store bits are 0. Outputs: fba=fbb=00, stall=0, flushE=0, wbenable=0. FSM is in RUN.
- Stage advance:
  - When o_con_stall=0, every shadow stage advances on each rising clk.
  - When o_con_flushE=1, a bubble (all control bits 0) enters E in place of the D values.
  - When o_con_stall=1, all shadow stages hold.
- Forwarding, combinational from the registered shadow state, shown for A (B is identical using rt):
  - rsE=0: select 00; register 0 is never forwarded.
  - Otherwise, if regwriteM and dstM==rsE: select 11 if loadM, else 10.
  - Otherwise, if regwriteW and dstW==rsE: select 01.
  - Otherwise: select 00.
  - M has priority over W when both match.
- A load followed immediately by a dependent instruction causes no stall; the dependent instruction receives select 11 when it reaches E.
- FSM states: RUN, MEMWAIT.
  - RUN to MEMWAIT: (loadM or storeM) and i_con_memready=0.
  - MEMWAIT to RUN: i_con_memready=1.
  - o_con_stall = (loadM or storeM) and not i_con_memready; this is combinational, so the stall is asserted in the first wait cycle.
  - The FSM state is used only for the optional counter and for debug.
- While stalled, the forwarding selects stay stable because all shadow stages hold.
- o_con_flushE = i_con_brtakenE and not o_con_stall. When branch and stall coincide, the flush is deferred until the cycle the stall releases, provided the branch is still asserted.
- o_con_wbenable = regwriteW and not o_con_stall, so a frozen W is not written repeatedly.
- Synchronous reset asserted mid-stall returns the FSM to RUN and clears all shadow state on the next edge, with no pending flush.

Optional Feature:
- Macro: FWD_HAZARD_STALLCNT_EN.
- When defined:
  - Adds output o_data_stallcnt, width STALL_CW.
  - Counter increments on every cycle with o_con_stall=1.
  - Saturates at all-ones.
  - Cleared by reset.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package fwd_pkg holds:
  - typedef fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_ALU_M=2'b10, FWD_MEM_M=2'b11); this encoding is shared with the E-stage operand muxes.
  - typedef for shadow-stage structs.
  - FSM state enum.
- One sub-module, fwd_sel_calc: the combinational per-operand select logic, instantiated twice (rs and rt).

Test Plan:
- Back-to-back ALU dependency: ADD r3 in D, next instruction uses r3 as rs -> that instruction in E has fba=10, fbb=00.
- Two-apart dependency: r3 written by the instruction two ahead -> fba=01. When the same register is written by both M and W -> 10 (M priority).
- Load-use: LW r4 then ADD using r4 as rt -> fbb=11, no stall. Destination r0 with regwrite=1 -> both selects 00.
- Memory wait: LW in M with memready low for 3 cycles:
  - stall=1 for exactly those 3 cycles, then 0.
  - Selects constant throughout; wbenable=0 while stalled.
  - With the macro defined, stallcnt increases by 3.
- Branch flush: brtakenE=1 -> flushE=1 and a bubble enters E next cycle. Branch coinciding with stall -> flushE=0 until the stall releases.
- Reset while in MEMWAIT: rst_n low for 1 edge -> all outputs 0 and FSM in RUN, and no forwarding from pre-reset state.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit and the E-stage operand muxes.
package fwd_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_WB    = 2'b01,
        FWD_ALU_M = 2'b10,
        FWD_MEM_M = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic regwrite;
        logic load;
        logic store;
    } ctl_t;

    typedef enum logic {
        StRun,
        StMemwait
    } fsm_e;

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding select for one E-stage operand; M result wins over W.
module fwd_sel_calc
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] dst_m,
    input  logic              regwrite_m,
    input  logic              load_m,
    input  logic [REG_AW-1:0] dst_w,
    input  logic              regwrite_w,
    output fwd_sel_e          sel
);

    always_comb begin
        sel = FWD_RF;
        // Register 0 is hardwired, so it never takes a forwarded value.
        if (src != '0) begin
            if (regwrite_m && (dst_m == src)) begin
                sel = load_m ? FWD_MEM_M : FWD_ALU_M;
            end else if (regwrite_w && (dst_w == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, memory-wait stall and branch flush for the 5-stage core.
// Define FWD_HAZARD_STALLCNT_EN to add the saturating stall-cycle counter output.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned STALL_CW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_addr_rsD,
    input  logic [REG_AW-1:0] i_addr_rtD,
    input  logic [REG_AW-1:0] i_addr_dstD,
    input  logic              i_con_regwriteD,
    input  logic              i_con_loadD,
    input  logic              i_con_storeD,
    input  logic              i_con_brtakenE,
    input  logic              i_con_memready,
    output logic [1:0]        o_con_fba,
    output logic [1:0]        o_con_fbb,
    output logic              o_con_stall,
    output logic              o_con_flushE,
    output logic              o_con_wbenable
`ifdef FWD_HAZARD_STALLCNT_EN
    ,
    output logic [STALL_CW-1:0] o_data_stallcnt
`endif
);

    if (STALL_CW < 1) begin : g_bad_cw
        $error("STALL_CW must be at least 1");
    end

    logic [REG_AW-1:0] rs_e_q, rt_e_q, dst_e_q, dst_m_q, dst_w_q;
    ctl_t              ctl_e_q, ctl_m_q;
    logic              regwrite_w_q;
    fsm_e              state_q, state_d;
    fwd_sel_e          sel_a, sel_b;
    logic              mem_m, stall, flush;

    assign mem_m = ctl_m_q.load | ctl_m_q.store;
    assign stall = mem_m & ~i_con_memready;
    assign flush = i_con_brtakenE & ~stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_e_q       <= '0;
            rt_e_q       <= '0;
            dst_e_q      <= '0;
            ctl_e_q      <= '0;
            dst_m_q      <= '0;
            ctl_m_q      <= '0;
            dst_w_q      <= '0;
            regwrite_w_q <= 1'b0;
        end else if (!stall) begin
            // A bubble also clears the addresses so it can never match a producer.
            if (flush) begin
                rs_e_q  <= '0;
                rt_e_q  <= '0;
                dst_e_q <= '0;
                ctl_e_q <= '0;
            end else begin
                rs_e_q  <= i_addr_rsD;
                rt_e_q  <= i_addr_rtD;
                dst_e_q <= i_addr_dstD;
                ctl_e_q <= '{regwrite: i_con_regwriteD, load: i_con_loadD, store: i_con_storeD};
            end
            dst_m_q      <= dst_e_q;
            ctl_m_q      <= ctl_e_q;
            dst_w_q      <= dst_m_q;
            regwrite_w_q <= ctl_m_q.regwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (mem_m && !i_con_memready) state_d = StMemwait;
            StMemwait: if (i_con_memready) state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_a (
        .src        (rs_e_q),
        .dst_m      (dst_m_q),
        .regwrite_m (ctl_m_q.regwrite),
        .load_m     (ctl_m_q.load),
        .dst_w      (dst_w_q),
        .regwrite_w (regwrite_w_q),
        .sel        (sel_a)
    );

    fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_b (
        .src        (rt_e_q),
        .dst_m      (dst_m_q),
        .regwrite_m (ctl_m_q.regwrite),
        .load_m     (ctl_m_q.load),
        .dst_w      (dst_w_q),
        .regwrite_w (regwrite_w_q),
        .sel        (sel_b)
    );

    assign o_con_fba      = sel_a;
    assign o_con_fbb      = sel_b;
    assign o_con_stall    = stall;
    assign o_con_flushE   = flush;
    assign o_con_wbenable = regwrite_w_q & ~stall;

`ifdef FWD_HAZARD_STALLCNT_EN
    logic [STALL_CW-1:0] stallcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallcnt_q <= '0;
        end else if (stall && (stallcnt_q != '1)) begin
            stallcnt_q <= stallcnt_q + STALL_CW'(1);
        end
    end

    assign o_data_stallcnt = stallcnt_q;
`else
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboarded bench for fwd_hazard_unit: one row of stimulus and expectation per cycle.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, dst;
    logic       rw, ld, st, br, mr;
    logic [1:0] fba, fbb;
    logic       stall, flush, wben;
`ifdef FWD_HAZARD_STALLCNT_EN
    logic [15:0] stallcnt;
`endif

    fwd_hazard_unit #(.REG_AW(5), .STALL_CW(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_addr_rsD      (rs),
        .i_addr_rtD      (rt),
        .i_addr_dstD     (dst),
        .i_con_regwriteD (rw),
        .i_con_loadD     (ld),
        .i_con_storeD    (st),
        .i_con_brtakenE  (br),
        .i_con_memready  (mr),
        .o_con_fba       (fba),
        .o_con_fbb       (fbb),
        .o_con_stall     (stall),
        .o_con_flushE    (flush),
        .o_con_wbenable  (wben)
`ifdef FWD_HAZARD_STALLCNT_EN
        ,
        .o_data_stallcnt (stallcnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rstn;
        logic [4:0] rs, rt, dst;
        logic       rw, ld, st, br, mr;
        logic [6:0] exp;   // {fba, fbb, stall, flush, wben}
    } row_t;

    logic [6:0] sb[$];
    logic [6:0] obs, want;
    int n_cmp = 0;
    int n_err = 0;

    assign obs = {fba, fbb, stall, flush, wben};

    function automatic row_t r(input logic rstn, input int a, b, d, input logic w, l, s, brt, mrd,
                               input int fa, fb, input logic sl, fl, wb);
        row_t x;
        x.rstn = rstn; x.rs = 5'(a); x.rt = 5'(b); x.dst = 5'(d);
        x.rw = w; x.ld = l; x.st = s; x.br = brt; x.mr = mrd;
        x.exp = {2'(fa), 2'(fb), sl, fl, wb};
        return x;
    endfunction

    // Drives one cycle of stimulus and queues what the outputs must be in that cycle.
    task automatic apply(input row_t x);
        rst_n = x.rstn; rs = x.rs; rt = x.rt; dst = x.dst;
        rw = x.rw; ld = x.ld; st = x.st; br = x.br; mr = x.mr;
        sb.push_back(x.exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rs = '0; rt = '0; dst = '0;
        rw = 0; ld = 0; st = 0; br = 0; mr = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        row_t t[$];
        do_reset();
        t = {r(1, 0,0,0, 0,0,0,0,0, 0,0,0,0,0), r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,0)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            want = sb.pop_front(); n_cmp++;
            if (obs !== want) begin
                n_err++; $display("FAIL reset[%0d]: got %b want %b", i, obs, want);
            end
            @(posedge clk); #1;
        end
`ifdef FWD_HAZARD_STALLCNT_EN
        n_cmp++;
        if (stallcnt !== 16'd0) begin
            n_err++; $display("FAIL reset_stallcnt: got %0d want 0", stallcnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        row_t t[$];
        do_reset();
        t = {r(1, 1,2,3, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 3,5,6, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 2,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,1),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,1)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            want = sb.pop_front(); n_cmp++;
            if (obs !== want) begin
                n_err++; $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_two_apart();
        row_t t[$];
        do_reset();
        t = {r(1, 1,2,3, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,0),
             r(1, 3,4,7, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 1,0,0,0,1),
             r(1, 0,0,3, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,3, 1,0,0,0,1, 0,0,0,0,1),
             r(1, 3,3,8, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 2,2,0,0,1)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            want = sb.pop_front(); n_cmp++;
            if (obs !== want) begin
                n_err++; $display("FAIL two_apart[%0d]: got %b want %b", i, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        row_t t[$];
        do_reset();
        t = {r(1, 1,0,4, 1,1,0,0,1, 0,0,0,0,0),
             r(1, 2,4,5, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 0,3,0,0,0),
             r(1, 1,1,0, 1,0,0,0,1, 0,0,0,0,1),
             r(1, 0,0,0, 1,0,0,0,1, 0,0,0,0,1),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,0)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            want = sb.pop_front(); n_cmp++;
            if (obs !== want) begin
                n_err++; $display("FAIL load_use[%0d]: got %b want %b", i, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        row_t t[$];
        do_reset();
        t = {r(1, 0,0,7, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 1,2,4, 1,1,0,0,1, 0,0,0,0,0),
             r(1, 4,6,5, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,0, 3,0,1,0,0),
             r(1, 0,0,0, 0,0,0,0,0, 3,0,1,0,0),
             r(1, 0,0,0, 0,0,0,0,0, 3,0,1,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 3,0,0,0,1),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,1)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            want = sb.pop_front(); n_cmp++;
            if (obs !== want) begin
                n_err++; $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, want);
            end
            @(posedge clk); #1;
        end
`ifdef FWD_HAZARD_STALLCNT_EN
        n_cmp++;
        if (stallcnt !== 16'd3) begin
            n_err++; $display("FAIL mem_wait_stallcnt: got %0d want 3", stallcnt);
        end
`endif
    endtask

    task automatic test_branch_flush();
        row_t t[$];
        do_reset();
        t = {r(1, 0,0,3, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 3,3,6, 1,0,0,1,1, 0,0,0,1,0),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,1),
             r(1, 1,2,0, 0,0,1,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,0),
             r(1, 3,3,3, 1,0,0,1,0, 0,0,1,0,0),
             r(1, 3,3,3, 1,0,0,1,1, 0,0,0,1,0),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,0)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            want = sb.pop_front(); n_cmp++;
            if (obs !== want) begin
                n_err++; $display("FAIL branch_flush[%0d]: got %b want %b", i, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midstall();
        row_t t[$];
        do_reset();
        t = {r(1, 0,0,3, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,4, 1,1,0,0,1, 0,0,0,0,0),
             r(1, 3,4,5, 1,0,0,0,1, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,1,0, 1,3,1,0,0),
             r(0, 0,0,0, 0,0,0,1,0, 1,3,1,0,0),
             r(1, 0,0,0, 0,0,0,0,0, 0,0,0,0,0),
             r(1, 0,0,0, 0,0,0,0,1, 0,0,0,0,0)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            want = sb.pop_front(); n_cmp++;
            if (obs !== want) begin
                n_err++; $display("FAIL reset_midstall[%0d]: got %b want %b", i, obs, want);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dut.state_q !== StRun) begin
            n_err++; $display("FAIL reset_midstall_fsm: got %0d want %0d", dut.state_q, StRun);
        end
`ifdef FWD_HAZARD_STALLCNT_EN
        n_cmp++;
        if (stallcnt !== 16'd0) begin
            n_err++; $display("FAIL reset_midstall_stallcnt: got %0d want 0", stallcnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_two_apart();
        test_load_use();
        test_mem_wait();
        test_branch_flush();
        test_reset_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
